// File: rtl/sa_pe_mac_pkg.sv
// Shared types and accumulator arithmetic for the systolic-array PE.
// sat_add works on a MAX_ACC_W container; only the low w bits are meaningful.
package sa_pkg;

  localparam int MAX_ACC_W = 64;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} pe_state_t;

  typedef struct packed {
    logic [MAX_ACC_W-1:0] sum;
    logic                 ovf;
  } add_res_t;

  function automatic logic [MAX_ACC_W-1:0] acc_mask(input int w);
    if (w >= MAX_ACC_W) return '1;
    return (MAX_ACC_W'(1) << w) - MAX_ACC_W'(1);
  endfunction

  function automatic logic [MAX_ACC_W-1:0] acc_max(input int w, input logic signed_mode);
    return signed_mode ? (acc_mask(w) >> 1) : acc_mask(w);
  endfunction

  function automatic logic [MAX_ACC_W-1:0] acc_min(input int w, input logic signed_mode);
    return signed_mode ? (MAX_ACC_W'(1) << (w - 1)) : '0;
  endfunction

  function automatic add_res_t sat_add(input logic [MAX_ACC_W-1:0] acc,
                                       input logic [MAX_ACC_W-1:0] addend,
                                       input int                   w,
                                       input logic                 signed_mode,
                                       input logic                 sat_mode);
    logic [MAX_ACC_W-1:0] mask, x, y, s;
    logic [MAX_ACC_W:0]   full;
    logic                 ovf, neg;
    add_res_t             r;
    mask = acc_mask(w);
    x    = acc & mask;
    y    = addend & mask;
    full = {1'b0, x} + {1'b0, y};
    s    = full[MAX_ACC_W-1:0] & mask;
    if (signed_mode) begin
      // Overflow only when both operands share a sign the sum does not.
      ovf = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
      neg = x[w-1];
    end else begin
      ovf = full[w];
      neg = 1'b0;
    end
    if (ovf && sat_mode) s = neg ? acc_min(w, 1'b1) : acc_max(w, signed_mode);
    r.sum = s;
    r.ovf = ovf;
    return r;
  endfunction

endpackage

// File: rtl/sa_pe_mac_if.sv
// Operand, forward and result bundle of one PE.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// valid never waits on ready, and the payload is stable while valid is held.
interface sa_pe_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) ();
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              fwd_vld;
  logic              res_vld;
  logic              res_rdy;
  logic [ACC_W-1:0]  res;
  logic              res_ovf;

  modport slave (
    input  in_vld, a_in, b_in, res_rdy,
    output in_rdy, a_out, b_out, fwd_vld, res_vld, res, res_ovf
  );

  modport master (
    output in_vld, a_in, b_in, res_rdy,
    input  in_rdy, a_out, b_out, fwd_vld, res_vld, res, res_ovf
  );
endinterface

// File: rtl/sa_mac_unit.sv
// Combinational multiply, extend to ACC_W and add into the accumulator.
module sa_mac_unit
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    addend;
  add_res_t            r;
  logic                unused_sum;

  generate
    if (SIGNED != 0) begin : g_signed
      assign prod   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
      assign addend = ACC_W'($signed(prod));
    end else begin : g_unsigned
      assign prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      assign addend = ACC_W'(prod);
    end
  endgenerate

  assign r          = sat_add(MAX_ACC_W'(acc), MAX_ACC_W'(addend), ACC_W, SIGNED != 0, SAT != 0);
  assign sum        = r.sum[ACC_W-1:0];
  assign ovf        = r.ovf;
  assign unused_sum = ^r.sum;
endmodule

// File: rtl/sa_pe_mac.sv
// Systolic PE: accumulates K_LEN operand products, holds the result until taken,
// and forwards each accepted operand pair east/south one cycle later.
module sa_pe_mac
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int K_LEN  = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic       CLK,
  input  logic       rst,
  sa_pe_mac_if.slave bus,
  output pe_state_t  state
);
  localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K_LEN - 1);

  pe_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic             ovf_sticky;
  logic             accept;
  logic             last_beat;

  assign bus.in_rdy  = (state == ACC);
  assign bus.res_vld = (state == HOLD);
  assign accept      = bus.in_vld & bus.in_rdy;
  assign last_beat   = accept && (cnt == LAST);

  sa_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_mac (
    .a   (bus.a_in),
    .b   (bus.b_in),
    .acc (acc),
    .sum (sum),
    .ovf (ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last_beat) state_nxt = HOLD;
      HOLD:    if (bus.res_rdy) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      ovf_sticky  <= 1'b0;
      bus.a_out   <= '0;
      bus.b_out   <= '0;
      bus.fwd_vld <= 1'b0;
      bus.res     <= '0;
      bus.res_ovf <= 1'b0;
    end else begin
      bus.fwd_vld <= accept;
      if (accept) begin
        bus.a_out <= bus.a_in;
        bus.b_out <= bus.b_in;
      end
      if (last_beat) begin
        bus.res     <= sum;
        bus.res_ovf <= ovf_sticky | ovf;
        acc         <= '0;
        cnt         <= '0;
        ovf_sticky  <= 1'b0;
      end else if (accept) begin
        acc        <= sum;
        cnt        <= cnt + CNT_W'(1);
        ovf_sticky <= ovf_sticky | ovf;
      end
    end
  end
endmodule

// File: tb/tb_sa_pe_mac.sv
// Directed bench for sa_pe_mac: a per-cycle vector table on an unsigned K=4 PE,
// plus hand sequences for reset, signed saturate/wrap and K_LEN=1.
module tb_sa_pe_mac;
  import sa_pkg::*;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  sa_pe_mac_if #(.DATA_W(8), .ACC_W(24)) bus0 ();
  sa_pe_mac_if #(.DATA_W(8), .ACC_W(16)) bus1 ();
  sa_pe_mac_if #(.DATA_W(8), .ACC_W(16)) bus2 ();
  sa_pe_mac_if #(.DATA_W(8), .ACC_W(24)) bus3 ();
  pe_state_t st0, st1, st2, st3;

  sa_pe_mac #(.DATA_W(8), .ACC_W(24), .K_LEN(4), .SIGNED(0), .SAT(1))
    u0 (.CLK(CLK), .rst(rst), .bus(bus0), .state(st0));
  sa_pe_mac #(.DATA_W(8), .ACC_W(16), .K_LEN(4), .SIGNED(1), .SAT(1))
    u1 (.CLK(CLK), .rst(rst), .bus(bus1), .state(st1));
  sa_pe_mac #(.DATA_W(8), .ACC_W(16), .K_LEN(4), .SIGNED(1), .SAT(0))
    u2 (.CLK(CLK), .rst(rst), .bus(bus2), .state(st2));
  sa_pe_mac #(.DATA_W(8), .ACC_W(24), .K_LEN(1), .SIGNED(0), .SAT(1))
    u3 (.CLK(CLK), .rst(rst), .bus(bus3), .state(st3));

  typedef struct {
    logic        vld;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        rdy;
    logic        e_fwd;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic        e_rv;
    logic [23:0] e_res;
    logic        e_ovf;
    logic        e_rdy;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl[NV];

  function automatic vec_t mk(logic vld, logic [7:0] a, logic [7:0] b, logic rdy,
                              logic e_fwd, logic [7:0] e_a, logic [7:0] e_b,
                              logic e_rv, logic [23:0] e_res, logic e_ovf, logic e_rdy);
    vec_t v;
    v.vld = vld; v.a = a; v.b = b; v.rdy = rdy;
    v.e_fwd = e_fwd; v.e_a = e_a; v.e_b = e_b;
    v.e_rv = e_rv; v.e_res = e_res; v.e_ovf = e_ovf; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive0(input logic vld, input logic [7:0] a, input logic [7:0] b, input logic rdy);
    bus0.in_vld = vld; bus0.a_in = a; bus0.b_in = b; bus0.res_rdy = rdy;
  endtask

  // Same operand stream into both signed PEs (saturating and wrapping).
  task automatic feed_s(input logic vld, input logic [7:0] a, input logic [7:0] b, input logic rdy);
    bus1.in_vld = vld; bus1.a_in = a; bus1.b_in = b; bus1.res_rdy = rdy;
    bus2.in_vld = vld; bus2.a_in = a; bus2.b_in = b; bus2.res_rdy = rdy;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    drive0(1'b0, 8'd0, 8'd0, 1'b0);
    bus1.in_vld = 0; bus1.a_in = 0; bus1.b_in = 0; bus1.res_rdy = 0;
    bus2.in_vld = 0; bus2.a_in = 0; bus2.b_in = 0; bus2.res_rdy = 0;
    bus3.in_vld = 0; bus3.a_in = 0; bus3.b_in = 0; bus3.res_rdy = 0;

    // Basic dot product 1*5+2*6+3*7+4*8 = 70
    tbl[0]  = mk(1, 1, 5, 1,  1, 1, 5, 0, 0,  0, 1);
    tbl[1]  = mk(1, 2, 6, 1,  1, 2, 6, 0, 0,  0, 1);
    tbl[2]  = mk(1, 3, 7, 1,  1, 3, 7, 0, 0,  0, 1);
    tbl[3]  = mk(1, 4, 8, 1,  1, 4, 8, 1, 70, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1,  0, 4, 8, 0, 70, 0, 1);
    // Backpressure: same stream, result held 5 cycles, offered operands ignored
    tbl[5]  = mk(1, 1, 5, 0,  1, 1, 5, 0, 70, 0, 1);
    tbl[6]  = mk(1, 2, 6, 0,  1, 2, 6, 0, 70, 0, 1);
    tbl[7]  = mk(1, 3, 7, 0,  1, 3, 7, 0, 70, 0, 1);
    tbl[8]  = mk(1, 4, 8, 0,  1, 4, 8, 1, 70, 0, 0);
    for (int i = 9; i < 14; i++) tbl[i] = mk(1, 9, 9, 0, 0, 4, 8, 1, 70, 0, 0);
    tbl[14] = mk(1, 9, 9, 1,  0, 4, 8, 0, 70, 0, 1);
    tbl[15] = mk(1, 1, 1, 0,  1, 1, 1, 0, 70, 0, 1);
    tbl[16] = mk(1, 1, 1, 0,  1, 1, 1, 0, 70, 0, 1);
    tbl[17] = mk(1, 1, 1, 0,  1, 1, 1, 0, 70, 0, 1);
    tbl[18] = mk(1, 1, 1, 0,  1, 1, 1, 1, 4,  0, 0);
    tbl[19] = mk(0, 0, 0, 1,  0, 1, 1, 0, 4,  0, 1);
    // Bubbles: valid 1,0,0,1,0,1,1 with a=b=2; junk on idle beats must not count
    tbl[20] = mk(1, 2, 2, 1,  1, 2, 2, 0, 4,  0, 1);
    tbl[21] = mk(0, 7, 7, 1,  0, 2, 2, 0, 4,  0, 1);
    tbl[22] = mk(0, 7, 7, 1,  0, 2, 2, 0, 4,  0, 1);
    tbl[23] = mk(1, 2, 2, 1,  1, 2, 2, 0, 4,  0, 1);
    tbl[24] = mk(0, 7, 7, 1,  0, 2, 2, 0, 4,  0, 1);
    tbl[25] = mk(1, 2, 2, 1,  1, 2, 2, 0, 4,  0, 1);
    tbl[26] = mk(1, 2, 2, 1,  1, 2, 2, 1, 16, 0, 0);
    tbl[27] = mk(0, 0, 0, 1,  0, 2, 2, 0, 16, 0, 1);

    // Reset state
    tick();
    tick();
    chk("rst_a_out",   32'(bus0.a_out),   0);
    chk("rst_b_out",   32'(bus0.b_out),   0);
    chk("rst_fwd_vld", 32'(bus0.fwd_vld), 0);
    chk("rst_res_vld", 32'(bus0.res_vld), 0);
    chk("rst_res",     32'(bus0.res),     0);
    chk("rst_res_ovf", 32'(bus0.res_ovf), 0);
    chk("rst_in_rdy",  32'(bus0.in_rdy),  1);
    chk("rst_state",   32'(st0),          32'(ACC));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive0(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].rdy);
      tick();
      chk($sformatf("v%0d_fwd_vld", i), 32'(bus0.fwd_vld), 32'(tbl[i].e_fwd));
      chk($sformatf("v%0d_a_out", i),   32'(bus0.a_out),   32'(tbl[i].e_a));
      chk($sformatf("v%0d_b_out", i),   32'(bus0.b_out),   32'(tbl[i].e_b));
      chk($sformatf("v%0d_res_vld", i), 32'(bus0.res_vld), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d_res", i),     32'(bus0.res),     32'(tbl[i].e_res));
      chk($sformatf("v%0d_res_ovf", i), 32'(bus0.res_ovf), 32'(tbl[i].e_ovf));
      chk($sformatf("v%0d_in_rdy", i),  32'(bus0.in_rdy),  32'(tbl[i].e_rdy));
    end

    // Reset mid-accumulation: two beats of 3*3, then reset
    drive0(1, 3, 3, 1); tick();
    drive0(1, 3, 3, 1); tick();
    drive0(0, 0, 0, 1); rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_a_out",   32'(bus0.a_out),   0);
    chk("mid_rst_fwd_vld", 32'(bus0.fwd_vld), 0);
    chk("mid_rst_res",     32'(bus0.res),     0);
    chk("mid_rst_res_vld", 32'(bus0.res_vld), 0);
    chk("mid_rst_in_rdy",  32'(bus0.in_rdy),  1);
    for (int i = 0; i < 4; i++) begin drive0(1, 1, 1, 0); tick(); end
    chk("post_rst_res",     32'(bus0.res),     4);
    chk("post_rst_res_vld", 32'(bus0.res_vld), 1);
    chk("post_rst_state",   32'(st0),          32'(HOLD));
    // Reset while HOLD waits discards the pending result
    drive0(0, 0, 0, 0); rst = 1'b1; tick(); rst = 1'b0;
    chk("hold_rst_res_vld", 32'(bus0.res_vld), 0);
    chk("hold_rst_res",     32'(bus0.res),     0);
    chk("hold_rst_state",   32'(st0),          32'(ACC));

    // Signed: 127*127 x4 saturates to 32767, wraps to 64516 = -1020
    for (int i = 0; i < 4; i++) feed_s(1, 8'd127, 8'd127, 0);
    chk("sat_pos_res", 32'(bus1.res), 32'h7fff);
    chk("sat_pos_ovf", 32'(bus1.res_ovf), 1);
    chk("wrap_pos_res", 32'(bus2.res), 32'hfc04);
    chk("wrap_pos_ovf", 32'(bus2.res_ovf), 1);
    feed_s(0, 0, 0, 1);
    // -128*127 x4: saturates to -32768; wraps to -65024 mod 2^16 = 512
    for (int i = 0; i < 4; i++) feed_s(1, 8'h80, 8'd127, 0);
    chk("sat_neg_res", 32'(bus1.res), 32'h8000);
    chk("sat_neg_ovf", 32'(bus1.res_ovf), 1);
    chk("wrap_neg_res", 32'(bus2.res), 32'h0200);
    chk("wrap_neg_ovf", 32'(bus2.res_ovf), 1);
    feed_s(0, 0, 0, 1);
    // -3*5 x4 = -60, in range: sticky overflow must have been cleared
    for (int i = 0; i < 4; i++) feed_s(1, 8'hfd, 8'd5, 0);
    chk("sgn_small_res", 32'(bus1.res), 32'hffc4);
    chk("sgn_small_ovf", 32'(bus1.res_ovf), 0);
    chk("sgn_small_wrap_res", 32'(bus2.res), 32'hffc4);
    chk("sgn_small_wrap_ovf", 32'(bus2.res_ovf), 0);
    feed_s(0, 0, 0, 1);

    // K_LEN=1: 3*5 every other cycle, in_rdy alternating
    bus3.in_vld = 1; bus3.a_in = 8'd3; bus3.b_in = 8'd5; bus3.res_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("k1_%0d_res_vld", i), 32'(bus3.res_vld), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("k1_%0d_in_rdy", i),  32'(bus3.in_rdy),  (i % 2 == 0) ? 0 : 1);
      chk($sformatf("k1_%0d_fwd_vld", i), 32'(bus3.fwd_vld), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("k1_%0d_res", i),     32'(bus3.res),     15);
    end
    bus3.in_vld = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sa_pe_mac.md
Name: sa_pe_mac

Overview:
- Parametrised systolic-array processing element (PE) for the matrix-multiply array.
- Accepts one (a, b) operand pair per handshake and accumulates K_LEN products into one dot-product result.
- Presents the result on a valid/ready output port and holds it until it is taken.
- Forwards each accepted operand east (a) and south (b) with a one-cycle register delay, so PEs tile into an N×N array.

Parameters:
- DATA_W, 8: width of operands a and b.
- ACC_W, 24: accumulator and result width. Must be >= 2*DATA_W.
- K_LEN, 16: number of products per dot product. Must be >= 1.
- SIGNED, 0: 1 = two's-complement operands and accumulator; 0 = unsigned.
- SAT, 1: 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- CLK, input, 1: clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_vld, input, 1: operand pair valid.
- in_rdy, output, 1: PE can accept an operand pair.
- a_in, input, DATA_W: row operand.
- b_in, input, DATA_W: column operand.
- a_out, output, DATA_W: registered copy of the last accepted a_in, to the east neighbour.
- b_out, output, DATA_W: registered copy of the last accepted b_in, to the south neighbour.
- fwd_vld, output, 1: one-cycle pulse; a_out/b_out carry a newly accepted pair.
- res_vld, output, 1: result valid.
- res_rdy, input, 1: downstream accepts the result.
- res, output, ACC_W: completed dot product.
- res_ovf, output, 1: overflow (or saturation) occurred during this result's accumulation.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= ACC, accumulator <= 0, beat counter <= 0.
  - a_out, b_out, res <= 0; fwd_vld, res_vld, res_ovf <= 0.
  - Reset takes priority over every other event, including mid-accumulation and while HOLD waits. No partial result is emitted.
- Accept: an operand pair is taken on a cycle with in_vld & in_rdy.
- State machine, two states:
  - ACC: in_rdy=1, res_vld=0.
    - On accept: acc <= acc (+) ext(a_in*b_in); cnt <= cnt+1.
    - On the accept where cnt==K_LEN-1: res <= acc (+) product; res_ovf <= ovf_sticky | ovf_this_beat; acc <= 0; cnt <= 0; ovf_sticky <= 0; go to HOLD.
    - No accept: all state is held. Gaps in in_vld are allowed and add no products.
  - HOLD: in_rdy=0, res_vld=1. res and res_ovf stay stable.
    - On res_rdy=1: res_vld <= 0, go to ACC. in_rdy rises the next cycle; there is no same-cycle re-accept.
    - res_rdy is ignored in ACC.
- Latency:
  - res_vld asserts the cycle after the K-th accept.
  - Minimum period per result is K_LEN+1 cycles, with res_rdy tied high.
- Forwarding:
  - On each accept: a_out <= a_in, b_out <= b_in, fwd_vld <= 1. Otherwise fwd_vld <= 0 and a_out/b_out hold.
  - The forward path has no backpressure (array runs in lockstep).
- Arithmetic:
  - Product is 2*DATA_W bits, signed or unsigned per SIGNED.
  - ext() sign-extends (SIGNED=1) or zero-extends to ACC_W.
  - (+) is the ACC_W-bit add with overflow detection.
    - Unsigned: carry out.
    - Signed: operands have equal signs and the sum sign differs.
  - SAT=1: on overflow, the result clamps to max (2^ACC_W-1 unsigned; 2^(ACC_W-1)-1 signed positive) or min (0 unsigned is unreachable; -2^(ACC_W-1) signed negative).
  - SAT=0: the result wraps.
  - ovf_this_beat is flagged in both modes. ovf_sticky ORs it across the K_LEN beats.
- K_LEN=1: every accept goes straight to HOLD.

Decomposition:
- Package sa_pkg:
  - pe_state_t enum {ACC, HOLD}.
  - Function sat_add(acc, addend, signed_mode, sat_mode) returning {sum, ovf}.
  - Localparam helpers for max/min accumulator values.
- Sub-module sa_mac_unit (combinational):
  - Multiply, extend and saturating add.
  - Parametrised on DATA_W/ACC_W/SIGNED/SAT; outputs sum and ovf.
- sa_pe_mac holds the FSM, counter, accumulator, forward registers and output registers.

Test Plan:
- Basic dot product (DATA_W=8, ACC_W=24, K_LEN=4, unsigned):
  - Stimulus: a=[1,2,3,4], b=[5,6,7,8] on consecutive cycles, res_rdy=1.
  - Response: res=70, res_ovf=0, res_vld high exactly 1 cycle after the 4th accept; fwd_vld pulses 4 times with a_out/b_out echoing inputs 1 cycle late.
- Backpressure:
  - Stimulus: same stream, res_rdy=0 for 5 cycles after res_vld.
  - Response: res=70 stable and in_rdy=0 throughout; the cycle after res_rdy=1, in_rdy=1 and the next result (a=b=[1,1,1,1]) gives res=4 (accumulator cleared).
- Bubbles:
  - Stimulus: in_vld toggling 1,0,0,1,0,1,1 with a=b=2 on valid beats, K_LEN=4.
  - Response: res=16, res_vld 1 cycle after the last valid beat.
- Signed saturation (SIGNED=1, SAT=1, ACC_W=16, K_LEN=4):
  - Stimulus: a=b=127 x4.
  - Response: res=32767, res_ovf=1.
  - Also a=-128, b=127 x4 gives res=-32768, res_ovf=1.
  - Same a=b=127 stream with SAT=0 gives res=-1020 (64516 wrapped), res_ovf=1.
- Reset mid-operation:
  - Stimulus: rst=1 after 2 of 4 beats, then a=b=[1,1,1,1].
  - Response: all outputs 0 after the reset edge; next res=4 (no carry-over from the aborted partial sum).
- K_LEN=1:
  - Stimulus: a=3, b=5 on every cycle, res_rdy=1.
  - Response: res=15 every other cycle; in_rdy alternates 1,0.
